// File: rtl/antilog_pkg.sv
// Shared constants and types for the antilog stage: exponent coefficient,
// mantissa width, frame FSM states and the sideband bundle carried with each sample.
package antilog_pkg;

   // log2(e) ~= 7/5, held as 45 in Q5
   localparam int LOG2E_Q5  = 45;
   localparam int MANT_BW   = 5;
   // Length field is sized for the widest supported frame counter
   localparam int SB_LEN_BW = 16;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      IN_FRAME = 1'b1
   } frame_state_t;

   typedef struct packed {
      logic [5:0]           idx;
      logic [6:0]           num;
      logic                 first;
      logic                 last;
      logic                 err;
      logic [SB_LEN_BW-1:0] len;
   } sideband_t;

endpackage

// File: rtl/antilog_core.sv
// Three-stage arithmetic datapath: scale the natural-log input to base 2,
// split it into integer exponent and fraction, then build the PWL 2^x result.
module antilog_core
   import antilog_pkg::*;
#(
   parameter int I_BW    = 14,
   parameter int FRAC_BW = 0,
   parameter int O_BW    = 14
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [I_BW-1:0] data_i,
   input  logic                   vld_i,
   output logic                   vld_p1_o,
   output logic                   vld_p2_o,
   output logic signed [O_BW-1:0] data_o,
   output logic                   vld_o
);

   localparam int T_W  = I_BW + 7;
   localparam int SH   = FRAC_BW + MANT_BW;
   localparam int E_W  = T_W - SH;
   localparam int SH_W = O_BW + MANT_BW + 1;

   localparam logic signed [T_W-1:0]  COEF  = T_W'(LOG2E_Q5);
   localparam logic signed [E_W-1:0]  E_SAT = E_W'(O_BW - 1);
   localparam logic signed [O_BW-1:0] Y_MAX = {1'b0, {(O_BW-1){1'b1}}};

   logic signed [T_W-1:0]  t_d, t_p1_q;
   logic signed [E_W-1:0]  e_d, e_p2_q;
   logic [MANT_BW-1:0]     f_d, f_p2_q;
   logic signed [O_BW-1:0] y_d, y_p3_q;
   logic                   vld_p1_q, vld_p2_q, vld_p3_q;

   // Mantissa 1.f in Q5 shifted by the exponent; negative exponents underflow to zero
   function automatic logic signed [O_BW-1:0] pwl_exp2(
      input logic signed [E_W-1:0] e,
      input logic [MANT_BW-1:0]    f
   );
      logic [SH_W-1:0] m;
      logic [SH_W-1:0] y;
      m = SH_W'({1'b1, f});
      y = (m << e) >> MANT_BW;
      if (e[E_W-1])
         return '0;
      if (e >= E_SAT)
         return Y_MAX;
      return O_BW'(y);
   endfunction

   assign t_d = T_W'(data_i) * COEF;
   assign e_d = t_p1_q[T_W-1:SH];
   assign f_d = t_p1_q[SH-1:FRAC_BW];
   assign y_d = pwl_exp2(e_p2_q, f_p2_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
         t_p1_q   <= '0;
         e_p2_q   <= '0;
         f_p2_q   <= '0;
         y_p3_q   <= '0;
      end else begin
         vld_p1_q <= vld_i;
         vld_p2_q <= vld_p1_q;
         vld_p3_q <= vld_p2_q;
         // stage 1: base conversion
         if (vld_i)
            t_p1_q <= t_d;
         // stage 2: exponent / fraction split
         if (vld_p1_q) begin
            e_p2_q <= e_d;
            f_p2_q <= f_d;
         end
         // stage 3: PWL exponential with underflow and saturation
         if (vld_p2_q)
            y_p3_q <= y_d;
      end
   end

   assign vld_p1_o = vld_p1_q;
   assign vld_p2_o = vld_p2_q;
   assign data_o   = y_p3_q;
   assign vld_o    = vld_p3_q;

endmodule

// File: rtl/antilog.sv
// Log-domain to linear converter: arithmetic core plus frame tracking and a
// sideband delay line that keeps group indices and frame flags aligned to data.
module antilog
   import antilog_pkg::*;
#(
   parameter int I_BW    = 14,
   parameter int FRAC_BW = 0,
   parameter int O_BW    = 14,
   parameter int CNT_BW  = 13
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [I_BW-1:0] data_i,
   input  logic [5:0]             in_group_idx,
   input  logic [6:0]             in_group_num,
   input  logic                   di_en,
   input  logic                   is_first_in,
   input  logic                   is_last_in,
   output logic signed [O_BW-1:0] data_o,
   output logic [5:0]             out_group_idx,
   output logic [6:0]             out_group_num,
   output logic                   do_en,
   output logic                   is_first_out,
   output logic                   is_last_out,
   output logic                   frame_err,
   output logic [CNT_BW-1:0]      frame_len
);

   frame_state_t      state_q;
   logic [CNT_BW-1:0] cnt_q;
   logic [CNT_BW-1:0] cnt_inc;
   sideband_t         sb_p1_q, sb_p2_q, sb_p3_q;
   logic              vld_p1, vld_p2;

   antilog_core #(
      .I_BW    (I_BW),
      .FRAC_BW (FRAC_BW),
      .O_BW    (O_BW)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .data_i   (data_i),
      .vld_i    (di_en),
      .vld_p1_o (vld_p1),
      .vld_p2_o (vld_p2),
      .data_o   (data_o),
      .vld_o    (do_en)
   );

   // Counter sticks at full scale on very long frames
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

   // stage 1: frame FSM decides err/len for the entering sample
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sb_p1_q <= '0;
      end else if (di_en) begin
         sb_p1_q.idx   <= in_group_idx;
         sb_p1_q.num   <= in_group_num;
         sb_p1_q.first <= is_first_in;
         sb_p1_q.last  <= is_last_in;
         sb_p1_q.err   <= 1'b0;
         sb_p1_q.len   <= '0;
         case (state_q)
            IDLE: begin
               if (!is_first_in)
                  sb_p1_q.err <= 1'b1;
               else if (is_last_in)
                  sb_p1_q.len <= SB_LEN_BW'(1);
               else begin
                  state_q <= IN_FRAME;
                  cnt_q   <= CNT_BW'(1);
               end
            end
            IN_FRAME: begin
               if (is_first_in) begin
                  sb_p1_q.err <= 1'b1;
                  if (is_last_in) begin
                     sb_p1_q.len <= SB_LEN_BW'(1);
                     state_q     <= IDLE;
                  end else
                     cnt_q <= CNT_BW'(1);
               end else if (is_last_in) begin
                  sb_p1_q.len <= SB_LEN_BW'(cnt_inc);
                  state_q     <= IDLE;
               end else
                  cnt_q <= cnt_inc;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // stages 2-3: sideband follows the core valids; error is a qualified pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb_p2_q <= '0;
         sb_p3_q <= '0;
      end else begin
         if (vld_p1)
            sb_p2_q <= sb_p1_q;
         if (vld_p2)
            sb_p3_q <= sb_p2_q;
         sb_p3_q.err <= vld_p2 & sb_p2_q.err;
      end
   end

   assign out_group_idx = sb_p3_q.idx;
   assign out_group_num = sb_p3_q.num;
   assign is_first_out  = sb_p3_q.first;
   assign is_last_out   = sb_p3_q.last;
   assign frame_err     = sb_p3_q.err;
   assign frame_len     = CNT_BW'(sb_p3_q.len);

endmodule

// File: tb/tb_antilog.sv
// Self-checking bench for antilog: directed and randomized streams compared
// against an arithmetic reference of the exponential and the framing rules.
module tb_antilog;

   logic               clk;
   logic               rst;
   logic signed [13:0] data_i;
   logic [5:0]         in_group_idx;
   logic [6:0]         in_group_num;
   logic               di_en, is_first_in, is_last_in;
   logic signed [13:0] data_o;
   logic [5:0]         out_group_idx;
   logic [6:0]         out_group_num;
   logic               do_en, is_first_out, is_last_out, frame_err;
   logic [12:0]        frame_len;

   antilog dut (
      .clk           (clk),
      .rst           (rst),
      .data_i        (data_i),
      .in_group_idx  (in_group_idx),
      .in_group_num  (in_group_num),
      .di_en         (di_en),
      .is_first_in   (is_first_in),
      .is_last_in    (is_last_in),
      .data_o        (data_o),
      .out_group_idx (out_group_idx),
      .out_group_num (out_group_num),
      .do_en         (do_en),
      .is_first_out  (is_first_out),
      .is_last_out   (is_last_out),
      .frame_err     (frame_err),
      .frame_len     (frame_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // stimulus, captured outputs, expected outputs
   int s_vld[$], s_L[$], s_idx[$], s_num[$], s_first[$], s_last[$];
   int c_en[$], c_data[$], c_idx[$], c_num[$], c_first[$], c_last[$], c_err[$], c_len[$];
   int e_en[$], e_data[$], e_idx[$], e_num[$], e_first[$], e_last[$], e_err[$], e_len[$];

   // reference state: frame tracking and held output values
   int m_inframe = 0, m_cnt = 0;
   int h_data = 0, h_idx = 0, h_num = 0, h_first = 0, h_last = 0, h_len = 0;

   function automatic int ref_y(input int L);
      int t, e, f;
      t = L * 45;
      e = (t >= 0) ? t / 32 : -((-t + 31) / 32);
      f = t - e * 32;
      if (e < 0) return 0;
      if (e >= 13) return 8191;
      return ((32 + f) << e) / 32;
   endfunction

   // len = -1 marks a sample whose length is not defined (stray last in IDLE)
   task automatic frame_ref(input int first, input int last, output int err, output int len);
      err = 0;
      len = 0;
      if (first != 0) begin
         err = m_inframe;
         if (last != 0) begin
            len = 1;
            m_inframe = 0;
         end else begin
            m_inframe = 1;
            m_cnt = 1;
         end
      end else if (m_inframe == 0) begin
         err = 1;
         if (last != 0) len = -1;
      end else begin
         m_cnt = (m_cnt < 8191) ? m_cnt + 1 : 8191;
         if (last != 0) begin
            len = m_cnt;
            m_inframe = 0;
         end
      end
   endtask

   task automatic model_reset();
      m_inframe = 0; m_cnt = 0;
      h_data = 0; h_idx = 0; h_num = 0; h_first = 0; h_last = 0; h_len = 0;
   endtask

   task automatic clear_stim();
      s_vld.delete(); s_L.delete(); s_idx.delete(); s_num.delete(); s_first.delete(); s_last.delete();
   endtask

   task automatic add(input int v, input int L, input int idx, input int num, input int first, input int last);
      s_vld.push_back(v); s_L.push_back(L); s_idx.push_back(idx);
      s_num.push_back(num); s_first.push_back(first); s_last.push_back(last);
   endtask

   task automatic model_stream();
      int n, err, len;
      n = s_vld.size();
      e_en.delete(); e_data.delete(); e_idx.delete(); e_num.delete();
      e_first.delete(); e_last.delete(); e_err.delete(); e_len.delete();
      for (int k = 0; k < n + 3; k++) begin
         int j;
         j = k - 3;
         if (j >= 0 && s_vld[j] != 0) begin
            frame_ref(s_first[j], s_last[j], err, len);
            h_data = ref_y(s_L[j]); h_idx = s_idx[j]; h_num = s_num[j];
            h_first = s_first[j]; h_last = s_last[j]; h_len = len;
            e_en.push_back(1); e_err.push_back(err);
         end else begin
            e_en.push_back(0); e_err.push_back(0);
         end
         e_data.push_back(h_data); e_idx.push_back(h_idx); e_num.push_back(h_num);
         e_first.push_back(h_first); e_last.push_back(h_last); e_len.push_back(h_len);
      end
   endtask

   task automatic run_stream();
      int n;
      n = s_vld.size();
      c_en.delete(); c_data.delete(); c_idx.delete(); c_num.delete();
      c_first.delete(); c_last.delete(); c_err.delete(); c_len.delete();
      for (int k = 0; k < n + 3; k++) begin
         @(posedge clk); #1;
         c_en.push_back(int'(do_en)); c_data.push_back(int'(data_o));
         c_idx.push_back(int'(out_group_idx)); c_num.push_back(int'(out_group_num));
         c_first.push_back(int'(is_first_out)); c_last.push_back(int'(is_last_out));
         c_err.push_back(int'(frame_err)); c_len.push_back(int'(frame_len));
         if (k < n) begin
            di_en = s_vld[k][0]; data_i = 14'(s_L[k]);
            in_group_idx = 6'(s_idx[k]); in_group_num = 7'(s_num[k]);
            is_first_in = s_first[k][0]; is_last_in = s_last[k][0];
         end else begin
            di_en = 1'b0; is_first_in = 1'b0; is_last_in = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; di_en = 1'b0; data_i = '0; in_group_idx = '0; in_group_num = '0;
      is_first_in = 1'b0; is_last_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({do_en, frame_err, is_first_out, is_last_out} !== 4'b0) begin
         n_errors++; $display("FAIL reset_ctrl: got %b expected 0000", {do_en, frame_err, is_first_out, is_last_out});
      end
      n_checks++;
      if (data_o !== 14'sd0 || frame_len !== 13'd0 || out_group_idx !== 6'd0 || out_group_num !== 7'd0) begin
         n_errors++; $display("FAIL reset_data: data %0d len %0d idx %0d num %0d expected all 0", data_o, frame_len, out_group_idx, out_group_num);
      end
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_values();
      clear_stim();
      add(1, 0, 1, 2, 0, 0); add(1, 5, 1, 2, 0, 0); add(1, 9, 1, 2, 0, 0); add(0, 0, 0, 0, 0, 0);
      model_stream();
      run_stream();
      for (int k = 0; k < c_en.size(); k++) begin
         n_checks++;
         if (c_en[k] !== e_en[k] || c_data[k] !== e_data[k]) begin
            n_errors++; $display("FAIL values[%0d]: got en %0d data %0d expected en %0d data %0d", k, c_en[k], c_data[k], e_en[k], e_data[k]);
         end
      end
      n_checks++;
      if (c_en[2] !== 0 || c_en[3] !== 1 || c_en[4] !== 1 || c_en[5] !== 1 || c_en[6] !== 0) begin
         n_errors++; $display("FAIL values_latency: got en %0d%0d%0d%0d%0d expected 01110", c_en[2], c_en[3], c_en[4], c_en[5], c_en[6]);
      end
      n_checks++;
      if (c_data[3] !== 1 || c_data[4] !== 132 || c_data[5] !== 6784) begin
         n_errors++; $display("FAIL values_const: got %0d %0d %0d expected 1 132 6784", c_data[3], c_data[4], c_data[5]);
      end
   endtask

   task automatic test_saturate();
      clear_stim();
      add(1, 10, 0, 0, 0, 0); add(1, 8191, 0, 0, 0, 0); add(1, -1, 0, 0, 0, 0); add(1, -8192, 0, 0, 0, 0);
      model_stream();
      run_stream();
      for (int k = 0; k < c_en.size(); k++) begin
         n_checks++;
         if (c_en[k] !== e_en[k] || c_data[k] !== e_data[k]) begin
            n_errors++; $display("FAIL saturate[%0d]: got en %0d data %0d expected en %0d data %0d", k, c_en[k], c_data[k], e_en[k], e_data[k]);
         end
      end
      n_checks++;
      if (c_data[3] !== 8191 || c_data[4] !== 8191 || c_data[5] !== 0 || c_data[6] !== 0) begin
         n_errors++; $display("FAIL saturate_const: got %0d %0d %0d %0d expected 8191 8191 0 0", c_data[3], c_data[4], c_data[5], c_data[6]);
      end
   endtask

   task automatic test_single_sample();
      clear_stim();
      add(1, 3, 7, 40, 1, 1);
      model_stream();
      run_stream();
      n_checks++;
      if (c_en[3] !== 1 || c_data[3] !== 19 || c_len[3] !== 1 || c_err[3] !== 0) begin
         n_errors++; $display("FAIL single: got en %0d data %0d len %0d err %0d expected 1 19 1 0", c_en[3], c_data[3], c_len[3], c_err[3]);
      end
      n_checks++;
      if (c_idx[3] !== 7 || c_num[3] !== 40 || c_first[3] !== 1 || c_last[3] !== 1) begin
         n_errors++; $display("FAIL single_sb: got idx %0d num %0d first %0d last %0d expected 7 40 1 1", c_idx[3], c_num[3], c_first[3], c_last[3]);
      end
   endtask

   task automatic test_frame_bubble();
      int errs;
      errs = 0;
      clear_stim();
      add(1, 1, 0, 5, 1, 0); add(1, 2, 1, 5, 0, 0); add(0, 0, 0, 0, 0, 0);
      add(1, 3, 2, 5, 0, 0); add(1, 4, 3, 5, 0, 1);
      model_stream();
      run_stream();
      for (int k = 0; k < c_en.size(); k++) begin
         errs += c_err[k];
         n_checks++;
         if (c_en[k] !== e_en[k] || c_err[k] !== e_err[k] || c_idx[k] !== e_idx[k] || c_last[k] !== e_last[k]) begin
            n_errors++; $display("FAIL frame_bubble[%0d]: got en %0d err %0d idx %0d last %0d expected %0d %0d %0d %0d", k, c_en[k], c_err[k], c_idx[k], c_last[k], e_en[k], e_err[k], e_idx[k], e_last[k]);
         end
      end
      n_checks++;
      if (c_en[7] !== 1 || c_last[7] !== 1 || c_len[7] !== 4 || errs !== 0) begin
         n_errors++; $display("FAIL frame_len4: got en %0d last %0d len %0d errs %0d expected 1 1 4 0", c_en[7], c_last[7], c_len[7], errs);
      end
   endtask

   task automatic test_frame_violation();
      clear_stim();
      add(1, 2, 0, 1, 0, 0); add(1, 2, 1, 1, 1, 0); add(1, 2, 2, 1, 0, 0);
      add(1, 2, 3, 1, 1, 0); add(1, 2, 4, 1, 0, 0); add(1, 2, 5, 1, 0, 1);
      model_stream();
      run_stream();
      for (int k = 0; k < c_en.size(); k++) begin
         n_checks++;
         if (c_err[k] !== e_err[k] || c_en[k] !== e_en[k]) begin
            n_errors++; $display("FAIL violation[%0d]: got err %0d en %0d expected err %0d en %0d", k, c_err[k], c_en[k], e_err[k], e_en[k]);
         end
      end
      n_checks++;
      if (c_err[3] !== 1 || c_err[4] !== 0 || c_err[6] !== 1 || c_err[7] !== 0 || c_len[8] !== 3) begin
         n_errors++; $display("FAIL violation_const: got err %0d%0d%0d%0d len %0d expected 1010 len 3", c_err[3], c_err[4], c_err[6], c_err[7], c_len[8]);
      end
   endtask

   task automatic test_back_to_back();
      clear_stim();
      for (int i = 0; i < 400; i++) begin
         int L;
         if ($urandom_range(0, 3) == 0) L = int'($urandom_range(0, 16383)) - 8192;
         else L = int'($urandom_range(0, 24)) - 8;
         add(int'($urandom_range(0, 9) != 0), L, int'($urandom_range(0, 63)), int'($urandom_range(0, 88)),
             int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 7) == 0));
      end
      model_stream();
      run_stream();
      for (int k = 0; k < c_en.size(); k++) begin
         n_checks++;
         if (c_en[k] !== e_en[k] || c_data[k] !== e_data[k] || c_err[k] !== e_err[k]) begin
            n_errors++; $display("FAIL rand_data[%0d]: got en %0d data %0d err %0d expected %0d %0d %0d", k, c_en[k], c_data[k], c_err[k], e_en[k], e_data[k], e_err[k]);
         end
         n_checks++;
         if (c_idx[k] !== e_idx[k] || c_num[k] !== e_num[k] || c_first[k] !== e_first[k] || c_last[k] !== e_last[k]) begin
            n_errors++; $display("FAIL rand_sb[%0d]: got idx %0d num %0d first %0d last %0d expected %0d %0d %0d %0d", k, c_idx[k], c_num[k], c_first[k], c_last[k], e_idx[k], e_num[k], e_first[k], e_last[k]);
         end
         if (e_en[k] == 1 && e_last[k] == 1 && e_len[k] >= 0) begin
            n_checks++;
            if (c_len[k] !== e_len[k]) begin
               n_errors++; $display("FAIL rand_len[%0d]: got %0d expected %0d", k, c_len[k], e_len[k]);
            end
         end
      end
   endtask

   task automatic test_cnt_saturate();
      int last_k;
      clear_stim();
      add(1, 1, 0, 0, 1, 0);
      for (int i = 0; i < 8192; i++) add(1, 1, 0, 0, 0, 0);
      add(1, 1, 0, 0, 0, 1);
      model_stream();
      run_stream();
      last_k = c_en.size() - 1;
      n_checks++;
      if (c_en[last_k] !== 1 || c_last[last_k] !== 1 || c_len[last_k] !== 8191 || c_len[last_k] !== e_len[last_k]) begin
         n_errors++; $display("FAIL cnt_sat: got en %0d last %0d len %0d expected 1 1 8191", c_en[last_k], c_last[last_k], c_len[last_k]);
      end
   endtask

   task automatic test_reset_inflight();
      @(posedge clk); #1;
      di_en = 1'b1; data_i = 14'sd5; in_group_idx = 6'd9; in_group_num = 7'd9; is_first_in = 1'b1; is_last_in = 1'b0;
      @(posedge clk); #1;
      data_i = 14'sd9; is_first_in = 1'b0;
      @(posedge clk); #1;
      di_en = 1'b0; rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         n_checks++;
         if (do_en !== 1'b0 || data_o !== 14'sd0 || out_group_idx !== 6'd0 || frame_len !== 13'd0 || frame_err !== 1'b0) begin
            n_errors++; $display("FAIL reset_flight[%0d]: got en %0d data %0d idx %0d len %0d err %0d expected all 0", k, do_en, data_o, out_group_idx, frame_len, frame_err);
         end
      end
      clear_stim();
      add(1, 0, 2, 3, 0, 0);
      model_stream();
      run_stream();
      n_checks++;
      if (c_en[3] !== 1 || c_err[3] !== 1 || c_err[3] !== e_err[3] || c_data[3] !== 1) begin
         n_errors++; $display("FAIL reset_idle: got en %0d err %0d data %0d expected 1 1 1", c_en[3], c_err[3], c_data[3]);
      end
   endtask

   initial begin
      test_reset();
      test_values();
      test_saturate();
      test_single_sample();
      test_frame_bubble();
      test_frame_violation();
      test_back_to_back();
      test_cnt_saturate();
      test_reset_inflight();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
